// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: counts synchronized rising edges of osc_in over a GATE_CYCLES window.
// Optional range alarms are built when OSC_FREQ_METER_ALARM_EN is defined.
module osc_freq_meter #(
  parameter int GATE_CYCLES = 4096,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LO_LIMIT    = 0,
  parameter int HI_LIMIT    = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             alarm_lo,
  output logic             alarm_hi
);

  localparam int              GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   count_valid_q, count_valid_d;
  logic                   edge_det;
  logic [CNT_W-1:0]       edge_inc;
  logic                   result_ld;

  // Synchronizer and edge detector run in every state; only GATE consumes edge_det.
  assign sync_d      = {sync_q[SYNC_STAGES-2:0], osc_in};
  assign sync_prev_d = sync_q[SYNC_STAGES-1];
  assign edge_det    = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign edge_inc    = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;

  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    result_ld     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = GATE;
          gate_cnt_d = GATE_LOAD;
          edge_cnt_d = '0;
        end
      end
      GATE: begin
        edge_cnt_d = edge_inc;
        gate_cnt_d = gate_cnt_q - 1'b1;
        if (!en) begin
          state_d = IDLE;
        end else if (gate_cnt_q == '0) begin
          // Result is loaded on entry to DONE so count and count_valid appear together.
          state_d       = DONE;
          count_d       = edge_inc;
          count_valid_d = 1'b1;
          result_ld     = 1'b1;
        end
      end
      DONE: begin
        if (en) begin
          state_d    = GATE;
          gate_cnt_d = GATE_LOAD;
          edge_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      sync_prev_q   <= 1'b0;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      sync_prev_q   <= sync_prev_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign busy        = (state_q == GATE);
  assign count       = count_q;
  assign count_valid = count_valid_q;

`ifdef OSC_FREQ_METER_ALARM_EN
  logic alarm_lo_q, alarm_lo_d, alarm_hi_q, alarm_hi_d;

  always_comb begin
    alarm_lo_d = alarm_lo_q;
    alarm_hi_d = alarm_hi_q;
    if (result_ld) begin
      alarm_lo_d = (edge_inc < CNT_W'(LO_LIMIT));
      alarm_hi_d = (edge_inc > CNT_W'(HI_LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_lo_q <= 1'b0;
      alarm_hi_q <= 1'b0;
    end else begin
      alarm_lo_q <= alarm_lo_d;
      alarm_hi_q <= alarm_hi_d;
    end
  end

  assign alarm_lo = alarm_lo_q;
  assign alarm_hi = alarm_hi_q;
`else
  logic unused_alarm;
  assign unused_alarm = result_ld ^ (LO_LIMIT != 0) ^ (HI_LIMIT != 0);
  assign alarm_lo     = 1'b0;
  assign alarm_hi     = 1'b0;
`endif

endmodule
